// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Control sequencer for a multi-cycle RV32I core that supports R-type, I-type
//   ALU, load and store instructions. It walks each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It drives the IR and PC enables,
//   the immediate-format select, the ALU operand and op, the register-file
//   write enable and the data-memory strobes. It also keeps a count of
//   retired instructions.
//
// Parameters:
//   INSTRUCTION  instruction / datapath width (32 for RV32I)
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   instruction  IR contents; stable from DECODE until the next FETCH
//   imem_valid   instruction memory data valid (looked at in FETCH only)
//   dmem_ready   data memory access done (looked at in MEM only)
//   imem_req     instruction fetch request (held for the whole fetch wait)
//   ir_en        load IR from imem data (same cycle as imem_valid in FETCH)
//   pc_en        PC <= PC+4; this is the retire strobe
//   imm_sel      0 = I-format immediate, 1 = S-format immediate
//   alu_src      0 = rs2, 1 = immediate
//   alu_ctrl     {op_mod, funct3}
//   reg_we       register-file write enable (WB only)
//   wb_sel       0 = ALU result, 1 = load data
//   dmem_re      data read strobe (held until dmem_ready)
//   dmem_we      data write strobe (held until dmem_ready)
//   illegal      unsupported opcode detected
//   state_o      current state encoding, for debug
//   instret      retired instruction count (wraps)
//
// Configuration macro: ILLEGAL_TRAP_EN
//   defined   : an illegal opcode sends the FSM from DECODE to TRAP. TRAP holds
//               illegal=1 until rst and issues no retire, write or memory strobe.
//   undefined : an illegal opcode is retired as a NOP straight from DECODE,
//               with illegal=1 and pc_en=1 for that one cycle.
// ----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int INSTRUCTION = 32,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTRUCTION-1:0] instruction,
    input  logic                   imem_valid,
    input  logic                   dmem_ready,
    output logic                   imem_req,
    output logic                   ir_en,
    output logic                   pc_en,
    output logic                   imm_sel,
    output logic                   alu_src,
    output logic [3:0]             alu_ctrl,
    output logic                   reg_we,
    output logic                   wb_sel,
    output logic                   dmem_re,
    output logic                   dmem_we,
    output logic                   illegal,
    output logic [2:0]             state_o,
    output logic [CNT_W-1:0]       instret
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_L = 7'b0000011;
    localparam logic [6:0] OPC_S = 7'b0100011;

    state_t           state_reg;
    logic [CNT_W-1:0] instret_reg;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    // The IR is held stable from DECODE onward. So the class and ALU
    // control are decoded straight from it, with no extra pipeline register.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       is_r;
    logic       is_i;
    logic       is_l;
    logic       is_s;
    logic       is_legal;
    logic [3:0] alu_ctrl_dec;

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign funct7_5 = instruction[30];

    assign is_r     = (opcode == OPC_R);
    assign is_i     = (opcode == OPC_I);
    assign is_l     = (opcode == OPC_L);
    assign is_s     = (opcode == OPC_S);
    assign is_legal = is_r | is_i | is_l | is_s;

    // Register, operand and immediate fields are consumed by the datapath.
    // This block only needs opcode, funct3 and bit 30.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction;

    // For I-type, bit 30 only selects SRAI vs SRLI (funct3 = 101).
    // For every other I-type it is part of the immediate and must not
    // change the op (for example, addi with a negative immediate).
    // Loads and stores always add to compute the address.
    always_comb begin
        alu_ctrl_dec = 4'b0000;
        if (is_r) begin
            alu_ctrl_dec = {funct7_5, funct3};
        end else if (is_i) begin
            alu_ctrl_dec = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
        end
    end

    // ------------------------------------------------------------------
    // State register and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            instret_reg <= '0;
        end else begin
            if (pc_en) begin
                instret_reg <= instret_reg + 1'b1;
            end

            case (state_reg)
                ST_FETCH: begin
                    if (imem_valid) begin
                        state_reg <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_legal) begin
                        state_reg <= ST_EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_reg <= ST_TRAP;
`else
                        state_reg <= ST_FETCH;
`endif
                    end
                end
                ST_EXEC: begin
                    if (is_l || is_s) begin
                        state_reg <= ST_MEM;
                    end else begin
                        state_reg <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        state_reg <= is_l ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB: begin
                    state_reg <= ST_FETCH;
                end
                ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                    // Only rst leaves TRAP.
                    state_reg <= ST_TRAP;
`else
                    // TRAP cannot be reached in this build. Recover anyway.
                    state_reg <= ST_FETCH;
`endif
                end
                default: begin
                    state_reg <= ST_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    // Outputs come from the registered state plus the held IR. The two
    // handshake replies (ir_en, store pc_en) must also follow the memory
    // inputs in the same cycle, so they cannot be registered.
    // Every output is forced low while rst is high. Then an abort in the
    // middle of an instruction cannot leak a retire, a write or a strobe
    // in the reset cycle.
    always_comb begin
        imem_req = 1'b0;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        imm_sel  = 1'b0;
        alu_src  = 1'b0;
        alu_ctrl = 4'b0000;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        illegal  = 1'b0;

        if (!rst) begin
            // Decoded controls stay valid from DECODE through WB/MEM.
            if (state_reg == ST_DECODE || state_reg == ST_EXEC ||
                state_reg == ST_MEM    || state_reg == ST_WB) begin
                alu_src  = is_i | is_l | is_s;
                imm_sel  = is_s;
                wb_sel   = is_l;
                alu_ctrl = alu_ctrl_dec;
            end

            case (state_reg)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_en    = imem_valid;
                end
                ST_DECODE: begin
                    if (!is_legal) begin
                        illegal = 1'b1;
`ifndef ILLEGAL_TRAP_EN
                        // Treat it as a NOP: retire it straight away.
                        pc_en   = 1'b1;
`endif
                    end
                end
                ST_MEM: begin
                    dmem_re = is_l;
                    dmem_we = is_s;
                    // A store retires on the same cycle its write completes.
                    pc_en   = is_s & dmem_ready;
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    pc_en  = 1'b1;
                end
                ST_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o = state_reg;
    assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl.
// - A driver issues directed and random instructions. It models instruction
//   and data memories with random wait states.
// - For every instruction the driver expects to retire, a reference model
//   works out the whole expected transaction from the ISA rules: latency,
//   fetch cycles, strobe counts, decoded controls and instret. It pushes
//   this record into a queue.
// - A monitor gathers what the DUT did for each instruction. On each retire
//   strobe (pc_en) it pops the queue and compares.
// - Directed sequences also cover reset state, reset during a MEM wait,
//   and (when ILLEGAL_TRAP_EN is defined) the trap state.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        imem_valid;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_en;
    logic        pc_en;
    logic        imm_sel;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        reg_we;
    logic        wb_sel;
    logic        dmem_re;
    logic        dmem_we;
    logic        illegal;
    logic [2:0]  state_o;
    logic [31:0] instret;

    multicycle_ctrl #(.INSTRUCTION(32), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .imem_valid  (imem_valid),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .ir_en       (ir_en),
        .pc_en       (pc_en),
        .imm_sel     (imm_sel),
        .alu_src     (alu_src),
        .alu_ctrl    (alu_ctrl),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .dmem_re     (dmem_re),
        .dmem_we     (dmem_we),
        .illegal     (illegal),
        .state_o     (state_o),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic        legal;
        int          lat;      // ir_en cycle .. pc_en cycle, inclusive
        int          fcnt;     // cycles with imem_req high
        int          n_re;
        int          n_we;
        int          n_regwe;
        int          n_ill;
        logic [3:0]  alu_ctrl;
        logic        alu_src;
        logic        imm_sel;
        logic        wb_sel;
        logic        wb_at;    // wb_sel seen while reg_we is high
        logic        imm_at;   // imm_sel seen while dmem_we is high
        logic [31:0] instret;  // instret value during the retire cycle
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the expected transaction for one instruction.
    // fw = imem wait cycles, mw = dmem wait cycles, cnt = retires so far.
    // ------------------------------------------------------------------
    function automatic exp_t model(input logic [31:0] ins, input int fw, input int mw,
                                   input logic [31:0] cnt);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic r, i, l, s;
        opc = ins[6:0];
        f3  = ins[14:12];
        r = (opc == 7'h33);
        i = (opc == 7'h13);
        l = (opc == 7'h03);
        s = (opc == 7'h23);
        e.instr    = ins;
        e.legal    = r | i | l | s;
        e.fcnt     = fw + 1;
        e.lat      = (r || i) ? 4 : s ? 4 + mw : l ? 5 + mw : 2;
        e.n_re     = l ? mw + 1 : 0;
        e.n_we     = s ? mw + 1 : 0;
        e.n_regwe  = (r || i || l) ? 1 : 0;
        e.n_ill    = e.legal ? 0 : 1;
        if (r)
            e.alu_ctrl = {ins[30], f3};
        else if (i)
            e.alu_ctrl = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
        else
            e.alu_ctrl = 4'd0;
        e.alu_src  = i | l | s;
        e.imm_sel  = s;
        e.wb_sel   = l;
        e.wb_at    = l;
        e.imm_at   = s;
        e.instret  = cnt;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: sampled on the falling edge, away from the active edge.
    // ------------------------------------------------------------------
    int         cyc = 0;
    int         start_cyc = 0;
    int         fcnt = 0, m_re = 0, m_we = 0, m_regwe = 0, m_ill = 0;
    logic       dec_pending = 1'b0;
    logic [3:0] c_alu_ctrl = '0;
    logic       c_alu_src = 1'b0, c_imm_sel = 1'b0, c_wb_sel = 1'b0;
    logic       c_wb_at = 1'b0, c_imm_at = 1'b0;
    int         n_ret = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            fcnt = 0; m_re = 0; m_we = 0; m_regwe = 0; m_ill = 0;
            dec_pending = 1'b0; c_wb_at = 1'b0; c_imm_at = 1'b0;
        end else begin
            // Decoded controls are sampled in DECODE, the cycle after ir_en.
            if (dec_pending) begin
                c_alu_ctrl = alu_ctrl;
                c_alu_src  = alu_src;
                c_imm_sel  = imm_sel;
                c_wb_sel   = wb_sel;
            end
            dec_pending = ir_en;
            if (ir_en) start_cyc = cyc;
            if (imem_req) fcnt++;
            if (dmem_re) m_re++;
            if (dmem_we) begin m_we++; c_imm_at = imm_sel; end
            if (reg_we) begin m_regwe++; c_wb_at = wb_sel; end
            if (illegal) m_ill++;
            if (pc_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire_queue_len", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_ret++;
                    $display("retire %0d instr=%08h lat=%0d fetch=%0d re=%0d we=%0d instret=%0d",
                             n_ret, e.instr, cyc - start_cyc + 1, fcnt, m_re, m_we, instret);
                    chk("latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
                    chk("fetch_cycles", 32'(fcnt), 32'(e.fcnt));
                    chk("dmem_re_cycles", 32'(m_re), 32'(e.n_re));
                    chk("dmem_we_cycles", 32'(m_we), 32'(e.n_we));
                    chk("reg_we_cycles", 32'(m_regwe), 32'(e.n_regwe));
                    chk("illegal_cycles", 32'(m_ill), 32'(e.n_ill));
                    chk("wb_sel_at_reg_we", 32'(c_wb_at), 32'(e.wb_at));
                    chk("imm_sel_at_dmem_we", 32'(c_imm_at), 32'(e.imm_at));
                    chk("instret_at_retire", instret, e.instret);
                    if (e.legal) begin
                        chk("alu_ctrl", 32'(c_alu_ctrl), 32'(e.alu_ctrl));
                        chk("alu_src", 32'(c_alu_src), 32'(e.alu_src));
                        chk("imm_sel", 32'(c_imm_sel), 32'(e.imm_sel));
                        chk("wb_sel", 32'(c_wb_sel), 32'(e.wb_sel));
                    end
                end
                fcnt = 0; m_re = 0; m_we = 0; m_regwe = 0; m_ill = 0;
                c_wb_at = 1'b0; c_imm_at = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    logic [31:0] model_cnt = 0;

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("imem_req_wait", 32'(imem_req), 32'd1);
    endtask

    task automatic issue(input logic [31:0] ins, input int fw, input int mw, input logic push);
        logic [6:0] opc;
        opc = ins[6:0];
        if (push) begin
            exp_q.push_back(model(ins, fw, mw, model_cnt));
            model_cnt++;
        end
        wait_req();
        for (int k = 0; k < fw; k++) begin
            // Noise: ready outside MEM and IR garbage during FETCH must be ignored.
            imem_valid  = 1'b0;
            dmem_ready  = 1'($urandom_range(0, 1));
            instruction = $urandom;
            @(posedge clk); #1;
        end
        dmem_ready  = 1'b0;
        instruction = ins;
        imem_valid  = 1'b1;
        @(posedge clk); #1;
        imem_valid  = 1'b0;
        if (opc == 7'h03 || opc == 7'h23) begin
            int n = 0;
            while (!(dmem_re || dmem_we) && n < 20) begin
                imem_valid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end
            chk("mem_strobe_wait", 32'(dmem_re | dmem_we), 32'd1);
            for (int k = 0; k < mw; k++) begin
                imem_valid = 1'($urandom_range(0, 1));
                dmem_ready = 1'b0;
                @(posedge clk); #1;
            end
            dmem_ready = 1'b1;
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            imem_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req_low", 32'(imem_req), 32'd0);
        chk("rst_pc_en_low", 32'(pc_en), 32'd0);
        rst = 1'b0;
        model_cnt = 0;
        #1;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_imem_req", 32'(imem_req), 32'd1);
    endtask

    function automatic logic [31:0] rand_instr(input int cls);
        logic [31:0] v;
        logic [6:0]  o;
        v = $urandom;
        case (cls)
            0: v[6:0] = 7'h33;
            1: v[6:0] = 7'h13;
            2: v[6:0] = 7'h03;
            3: v[6:0] = 7'h23;
            default: begin
                o = v[6:0];
                if (o == 7'h33 || o == 7'h13 || o == 7'h03 || o == 7'h23)
                    o = 7'h7F;
                v[6:0] = o;
            end
        endcase
        return v;
    endfunction

    initial begin
        int max_cls;
        int n;
        rst = 1'b1;
        instruction = 32'd0;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        do_reset();

        // Directed instructions.
        issue(32'h002081B3, 0, 0, 1'b1);   // add x3,x1,x2
        issue(32'h4100D093, 1, 0, 1'b1);   // srai x1,x1,16
        issue(32'hC0008093, 0, 0, 1'b1);   // addi x1,x1,-1024
        issue(32'h00812283, 0, 2, 1'b1);   // lw x5,8(x2), two wait cycles
        issue(32'h00512223, 0, 0, 1'b1);   // sw x5,4(x2), zero wait
`ifndef ILLEGAL_TRAP_EN
        issue(32'h0000007F, 0, 0, 1'b1);   // illegal opcode retired as a NOP
        max_cls = 4;
`else
        max_cls = 3;
`endif

        // Random instructions with random memory wait states.
        for (int t = 0; t < 80; t++) begin
            issue(rand_instr($urandom_range(0, max_cls)),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end

        // Reset during the second MEM wait cycle of a load.
        wait_req();
        instruction = 32'h00812283;
        imem_valid = 1'b1;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        n = 0;
        while (!dmem_re && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_dmem_re_first", 32'(dmem_re), 32'd1);
        @(posedge clk); #1;
        chk("abort_dmem_re_second", 32'(dmem_re), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_reg_we_in_rst", 32'(reg_we), 32'd0);
        @(posedge clk); #1;
        chk("abort_state_fetch", 32'(state_o), 32'd0);
        chk("abort_dmem_re_low", 32'(dmem_re), 32'd0);
        chk("abort_instret_zero", instret, 32'd0);
        rst = 1'b0;
        model_cnt = 0;
        #1;
        chk("abort_imem_req", 32'(imem_req), 32'd1);
        issue(32'h002081B3, 0, 0, 1'b1);
        issue(32'h00812283, 0, 0, 1'b1);

`ifdef ILLEGAL_TRAP_EN
        // Illegal opcode sends the FSM to TRAP, where it stays until reset.
        begin
            logic [31:0] saved;
            wait_req();
            saved = instret;
            instruction = 32'h0000007F;
            imem_valid = 1'b1;
            @(posedge clk); #1;
            imem_valid = 1'b0;
            chk("decode_illegal", 32'(illegal), 32'd1);
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                chk("trap_illegal", 32'(illegal), 32'd1);
                chk("trap_pc_en", 32'(pc_en), 32'd0);
                chk("trap_state", 32'(state_o), 32'd5);
            end
            chk("trap_instret", instret, saved);
            do_reset();
            issue(32'h00512223, 0, 1, 1'b1);
        end
`endif

        // Wait for the last retire to drain.
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
